// File: rtl/gpio_arbiter.sv
// gpio_arbiter: shares a single gpio register port between requester A (MCU)
// and requester B (auxiliary sequencer). Round-robin on ties, one access at a
// time: grant (cycle 0), strobe (cycle 1), read data returned (cycle 2).
// Optional macro GPIO_ARB_LOCK_EN adds a_lock_i, which lets A hold off B
// across a read-modify-write sequence.
module gpio_arbiter #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              a_req_i,
  input  logic              a_we_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [DATA_W-1:0] a_wdata_i,
`ifdef GPIO_ARB_LOCK_EN
  input  logic              a_lock_i,
`endif
  output logic              a_gnt_o,
  output logic              a_rvalid_o,
  output logic [DATA_W-1:0] a_rdata_o,
  input  logic              b_req_i,
  input  logic              b_we_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [DATA_W-1:0] b_wdata_i,
  output logic              b_gnt_o,
  output logic              b_rvalid_o,
  output logic [DATA_W-1:0] b_rdata_o,
  output logic              sel_o,
  output logic              read_o,
  output logic              write_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  input  logic [DATA_W-1:0] data_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, RDATA} state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;   // 1 = port B owns the current access
  logic                last_q,  last_d;    // 1 = port B was granted last
  logic                we_q,    we_d;
  logic [ADDR_W-1:0]   addr_q,  addr_d;
  logic [DATA_W-1:0]   data_q,  data_d;
  logic                a_gnt,   b_gnt;
  logic                a_win,   b_win, b_elig;

`ifdef GPIO_ARB_LOCK_EN
  logic                lock_q,  lock_d;

  // B is ineligible while A holds the lock
  assign b_elig = b_req_i & ~lock_q;
`else
  assign b_elig = b_req_i;
`endif

  // On a tie the port that was not granted last wins
  assign a_win = a_req_i & (~b_elig | last_q);
  assign b_win = b_elig & ~a_win;

  // Next-state logic: grant and capture in IDLE, one strobe cycle, optional read return
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    data_d  = data_q;
`ifdef GPIO_ARB_LOCK_EN
    lock_d  = lock_q;
`endif
    a_gnt   = 1'b0;
    b_gnt   = 1'b0;
    case (state_q)
      IDLE: begin
        if (a_win || b_win) begin
          a_gnt   = a_win;
          b_gnt   = b_win;
          owner_d = b_win;
          last_d  = b_win;
          we_d    = b_win ? b_we_i    : a_we_i;
          addr_d  = b_win ? b_addr_i  : a_addr_i;
          data_d  = b_win ? b_wdata_i : a_wdata_i;
`ifdef GPIO_ARB_LOCK_EN
          if (a_win) lock_d = a_lock_i;
`endif
          state_d = ACCESS;
        end
      end
      ACCESS:  state_d = we_q ? IDLE : RDATA;
      RDATA:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and captured-command registers; async reset returns to IDLE with A favoured
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
`ifdef GPIO_ARB_LOCK_EN
      lock_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
`ifdef GPIO_ARB_LOCK_EN
      lock_q  <= lock_d;
`endif
    end
  end

  // Grants are combinational from IDLE; gated so they read 0 while reset is held
  assign a_gnt_o = a_gnt & rstn_i;
  assign b_gnt_o = b_gnt & rstn_i;

  assign sel_o   = (state_q == ACCESS);
  assign read_o  = sel_o & ~we_q;
  assign write_o = sel_o & we_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;

  // Read data passes straight through to the owner only; the other port sees 0
  assign a_rvalid_o = (state_q == RDATA) & ~owner_q;
  assign b_rvalid_o = (state_q == RDATA) &  owner_q;
  assign a_rdata_o  = a_rvalid_o ? data_i : '0;
  assign b_rdata_o  = b_rvalid_o ? data_i : '0;

endmodule

// File: tb/tb_gpio_arbiter.sv
// tb_gpio_arbiter: scoreboard bench for gpio_arbiter. A transaction-level
// reference model predicts grants, strobes and read returns from the
// arbitration and timing rules; a monitor pops and compares on DUT events.
module tb_gpio_arbiter;
  localparam int AW = 2;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rstn_i = 1'b0;
  logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
`ifdef GPIO_ARB_LOCK_EN
  logic          a_lock = 1'b0;
`endif
  logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          sel, rd, wr;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] data_o;
  logic [DW-1:0] data_in = '0;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gpio_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk), .rstn_i(rstn_i),
    .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
`ifdef GPIO_ARB_LOCK_EN
    .a_lock_i(a_lock),
`endif
    .a_gnt_o(a_gnt), .a_rvalid_o(a_rvalid), .a_rdata_o(a_rdata),
    .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
    .b_gnt_o(b_gnt), .b_rvalid_o(b_rvalid), .b_rdata_o(b_rdata),
    .sel_o(sel), .read_o(rd), .write_o(wr), .addr_o(addr_o), .data_o(data_o),
    .data_i(data_in)
  );

  typedef struct { int cyc; bit port; } gnt_t;
  typedef struct { int cyc; bit we; logic [AW-1:0] addr; logic [DW-1:0] data; } stb_t;
  typedef struct { int cyc; bit port; logic [DW-1:0] data; } rv_t;

  gnt_t exp_gnt[$];
  stb_t exp_stb[$];
  rv_t  exp_rv[$];

  // Reference model state (transaction level)
  logic [DW-1:0] m_regs[4];
  int            m_busy = 0;     // cycles the shared port stays occupied
  bit            m_last_b = 1'b1;
  bit            m_lock = 1'b0;
  bit            a_gr = 1'b0, b_gr = 1'b0;

  // Environment gpio register file
  logic [DW-1:0] env_regs[4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Predict the outcome of this cycle's requests
  task automatic model_eval();
    bit a_ok, b_ok, port, we;
    logic [AW-1:0] ad;
    logic [DW-1:0] wd;
    a_gr = 1'b0;
    b_gr = 1'b0;
    if (m_busy > 0) begin
      m_busy--;
    end else begin
      a_ok = a_req;
      b_ok = b_req;
`ifdef GPIO_ARB_LOCK_EN
      if (m_lock) b_ok = 1'b0;
`endif
      if (a_ok && b_ok) begin
        if (m_last_b) a_gr = 1'b1; else b_gr = 1'b1;
      end else if (a_ok) a_gr = 1'b1;
      else if (b_ok) b_gr = 1'b1;
      if (a_gr || b_gr) begin
        port = b_gr;
        we = port ? b_we : a_we;
        ad = port ? b_addr : a_addr;
        wd = port ? b_wdata : a_wdata;
        exp_gnt.push_back('{cyc, port});
        exp_stb.push_back('{cyc + 1, we, ad, wd});
        if (we) m_regs[ad] = wd;
        else exp_rv.push_back('{cyc + 2, port, m_regs[ad]});
        m_busy = we ? 1 : 2;
        m_last_b = port;
`ifdef GPIO_ARB_LOCK_EN
        if (a_gr) m_lock = a_lock;
`endif
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic autodrop();
    if (a_gr) a_req = 1'b0;
    if (b_gr) b_req = 1'b0;
  endtask

  task automatic tick();
    step();
    autodrop();
    model_eval();
  endtask

  task automatic rnd_a(input bit lockable);
    a_req = 1'b1;
    a_we = 1'($urandom);
    a_addr = AW'($urandom);
    a_wdata = DW'($urandom);
`ifdef GPIO_ARB_LOCK_EN
    a_lock = lockable && ($urandom_range(3, 0) == 0);
`endif
  endtask

  task automatic rnd_b();
    b_req = 1'b1;
    b_we = 1'($urandom);
    b_addr = AW'($urandom);
    b_wdata = DW'($urandom);
  endtask

  // Raise one port's request with given fields and hold it until the model grants it
  task automatic issue(input bit port, input bit we, input logic [AW-1:0] ad,
                       input logic [DW-1:0] wd, input bit lk);
    bit done;
    step();
    autodrop();
    if (port) begin
      b_req = 1'b1; b_we = we; b_addr = ad; b_wdata = wd;
    end else begin
      a_req = 1'b1; a_we = we; a_addr = ad; a_wdata = wd;
`ifdef GPIO_ARB_LOCK_EN
      a_lock = lk;
`endif
    end
    model_eval();
    done = port ? b_gr : a_gr;
    for (int k = 0; k < 20 && !done; k++) begin
      step();
      autodrop();
      model_eval();
      done = port ? b_gr : a_gr;
    end
    if (!done) chk("issue_timeout", 64'(done), 64'(1));
    if (lk) ;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 6; k++) begin
      step();
      a_req = 1'b0;
      b_req = 1'b0;
      model_eval();
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata, sel, rd, wr, addr_o, data_o});
  endfunction

  // gpio environment: registers follow write strobes, read data appears the cycle after
  initial begin
    bit rd_p;
    logic [AW-1:0] rd_a;
    for (int i = 0; i < 4; i++) env_regs[i] = '0;
    forever begin
      @(negedge clk);
      rd_p = rd && rstn_i;
      rd_a = addr_o;
      if (wr && rstn_i) env_regs[addr_o] = data_o;
      @(posedge clk);
      #1;
      data_in = rd_p ? env_regs[rd_a] : DW'($urandom);
    end
  end

  // Monitor: compares DUT events against the expectation queues
  initial begin
    gnt_t g;
    stb_t s;
    rv_t  r;
    forever begin
      @(negedge clk);
      if (rstn_i) begin
        chk("gnt_overlap", 64'(a_gnt & b_gnt), 64'(0));
        chk("gnt_with_strobe", 64'((a_gnt | b_gnt) & (sel | rd | wr)), 64'(0));
        if (a_gnt || b_gnt) begin
          if (exp_gnt.size() == 0) chk("unexpected_gnt", 64'({a_gnt, b_gnt}), 64'(0));
          else begin
            g = exp_gnt.pop_front();
            chk("gnt_cycle", 64'(cyc), 64'(g.cyc));
            chk("gnt_port", 64'(b_gnt), 64'(g.port));
          end
        end
        if (sel) begin
          if (exp_stb.size() == 0) chk("unexpected_sel", 64'(sel), 64'(0));
          else begin
            s = exp_stb.pop_front();
            chk("stb_cycle", 64'(cyc), 64'(s.cyc));
            chk("stb_rw", 64'({rd, wr}), 64'({~s.we, s.we}));
            chk("stb_addr", 64'(addr_o), 64'(s.addr));
            if (s.we) chk("stb_data", 64'(data_o), 64'(s.data));
          end
        end else begin
          chk("strobe_outside_access", 64'({rd, wr}), 64'(0));
        end
        if (a_rvalid || b_rvalid) begin
          if (exp_rv.size() == 0) chk("unexpected_rvalid", 64'({a_rvalid, b_rvalid}), 64'(0));
          else begin
            r = exp_rv.pop_front();
            chk("rv_cycle", 64'(cyc), 64'(r.cyc));
            chk("rv_port", 64'({a_rvalid, b_rvalid}), 64'(r.port ? 2'b01 : 2'b10));
            chk("rv_data", 64'(r.port ? b_rdata : a_rdata), 64'(r.data));
          end
        end
        chk("rdata_gating", 64'({a_rvalid ? '0 : a_rdata, b_rvalid ? '0 : b_rdata}), 64'(0));
      end
    end
  end

  // Stimulus
  initial begin
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", all_outs(), 64'(0));
    @(posedge clk);
    #3;
    rstn_i = 1'b1;
    @(negedge clk);
    chk("post_reset_outputs", all_outs(), 64'(0));

    // Both ports request continuously from reset: grants alternate A,B,A,B
    step();
    rnd_a(1'b0);
    rnd_b();
    model_eval();
    for (int k = 0; k < 16; k++) begin
      step();
      if (a_gr) rnd_a(1'b0);
      if (b_gr) rnd_b();
      model_eval();
    end
    wait_idle();

    // Directed write from A, then B writes and reads back a known value
    issue(1'b0, 1'b1, 2'd0, 16'h00A5, 1'b0);
    wait_idle();
    issue(1'b1, 1'b1, 2'd1, 16'h1234, 1'b0);
    wait_idle();
    issue(1'b1, 1'b0, 2'd1, 16'h0000, 1'b0);
    wait_idle();

    // A pulses its request for one cycle while B's access is in flight
    issue(1'b1, 1'b0, 2'd2, 16'h0000, 1'b0);
    step(); autodrop(); a_req = 1'b1; a_we = 1'b1; a_addr = 2'd3; a_wdata = 16'hBEEF; model_eval();
    step(); a_req = 1'b0; model_eval();
    wait_idle();

`ifdef GPIO_ARB_LOCK_EN
    // Locked read by A holds B off until A's unlocking write completes
    issue(1'b0, 1'b0, 2'd3, 16'h0000, 1'b1);
    step(); autodrop(); b_req = 1'b1; b_we = 1'b0; b_addr = 2'd0; b_wdata = '0; model_eval();
    for (int k = 0; k < 4; k++) tick();
    issue(1'b0, 1'b1, 2'd3, 16'h5A5A, 1'b0);
    for (int k = 0; k < 6; k++) tick();
    wait_idle();
`endif

    // Randomised traffic with aborts and back-to-back re-requests
    for (int i = 0; i < 2500; i++) begin
      step();
      if (a_gr) begin
        if ($urandom_range(1, 0) == 1) rnd_a(1'b1); else a_req = 1'b0;
      end else if (a_req) begin
        if ($urandom_range(15, 0) == 0) a_req = 1'b0;
      end else if ($urandom_range(2, 0) == 0) rnd_a(1'b1);
      if (b_gr) begin
        if ($urandom_range(1, 0) == 1) rnd_b(); else b_req = 1'b0;
      end else if (b_req) begin
        if ($urandom_range(15, 0) == 0) b_req = 1'b0;
      end else if ($urandom_range(2, 0) == 0) rnd_b();
      model_eval();
    end
    wait_idle();
`ifdef GPIO_ARB_LOCK_EN
    issue(1'b0, 1'b1, 2'd0, 16'h0001, 1'b0);
    wait_idle();
`endif

    // Reset asserted while A's read is in its strobe cycle
    issue(1'b0, 1'b0, 2'd2, 16'h0000, 1'b0);
    step(); autodrop(); model_eval();
    @(negedge clk);
    #1;
    rstn_i = 1'b0;
    #1;
    chk("reset_mid_access", all_outs(), 64'(0));
    exp_rv.delete();
    m_busy = 0;
    m_last_b = 1'b1;
    m_lock = 1'b0;
    a_gr = 1'b0;
    b_gr = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rstn_i = 1'b1;
    wait_idle();
    issue(1'b0, 1'b0, 2'd2, 16'h0000, 1'b0);
    wait_idle();

    chk("pending_gnt", 64'(exp_gnt.size()), 64'(0));
    chk("pending_stb", 64'(exp_stb.size()), 64'(0));
    chk("pending_rv", 64'(exp_rv.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  // Run-time bound
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
